intp_deci_sched: RTL and testbench

//  Strobe scheduler for the interpolation/decimation hold stage: generates the
//  eni (input-sample) and eno (output-sample) clock enables from two fractional

---
 rtl/intp_deci_sched_pkg.sv | 16 +
 rtl/intp_deci_sched_if.sv | 37 +++
 rtl/intp_deci_sched_phase_acc.sv | 39 +++
 rtl/intp_deci_sched.sv | 109 ++++++++++
 tb/tb_intp_deci_sched.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/intp_deci_sched_pkg.sv
// intp_deci_pkg: shared constants and types for the interpolation/decimation
// strobe scheduler.
//   PW_DEF     default phase accumulator width
//   CW_DEF     default width of the saturating drop/fill counters
//   rate_cfg_t pair of strobe increments {inc_i, inc_o} at the default width
package intp_deci_pkg;

  localparam int PW_DEF = 32;
  localparam int CW_DEF = 16;

  typedef struct packed {
    logic [PW_DEF-1:0] inc_i;
    logic [PW_DEF-1:0] inc_o;
  } rate_cfg_t;

endpackage

// File: rtl/intp_deci_sched_if.sv
// intp_deci_sched_if: control/status bundle of the strobe scheduler.
//   run        accumulators advance while high
//   cfg_wr     capture cfg_inc_i/cfg_inc_o into the shadow registers
//   cfg_pend   a shadow configuration is waiting to be applied
//   cnt_clr    clear drop_cnt/fill_cnt
//   eni/eno    one-cycle input/output sample enables
//   full       hold register holds an unconsumed input sample
//   drop_cnt   input samples overwritten before being output (saturating)
//   fill_cnt   output strobes that found no fresh sample (saturating)
// There is no valid/ready handshake on this bundle: every input is sampled on
// each rising clk edge, and eni/eno are single-cycle pulses with no back-pressure.
interface intp_deci_sched_if #(
  parameter int PW = 32,
  parameter int CW = 16
);
  logic          run;
  logic          cfg_wr;
  logic [PW-1:0] cfg_inc_i;
  logic [PW-1:0] cfg_inc_o;
  logic          cfg_pend;
  logic          cnt_clr;
  logic          eni;
  logic          eno;
  logic          full;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fill_cnt;

  modport master (
    output run, cfg_wr, cfg_inc_i, cfg_inc_o, cnt_clr,
    input  cfg_pend, eni, eno, full, drop_cnt, fill_cnt
  );

  modport slave (
    input  run, cfg_wr, cfg_inc_i, cfg_inc_o, cnt_clr,
    output cfg_pend, eni, eno, full, drop_cnt, fill_cnt
  );
endinterface

// File: rtl/intp_deci_sched_phase_acc.sv
// phase_acc_strobe: fractional phase accumulator producing a strobe at an
// average rate of inc / 2**PW of clk.
//   clk  clock
//   rst  synchronous active-high reset (phase and strobe cleared)
//   run  1: accumulate; 0: hold phase, strobe forced low
//   inc  phase increment; 0 means the strobe never fires
//   stb  registered carry of the wrapping add (one-cycle pulse)
module phase_acc_strobe #(
  parameter int PW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic [PW-1:0] inc,
  output logic          stb
);

  logic [PW-1:0] r_acc;
  logic          r_stb;
  logic [PW:0]   w_sum;

  // One extra bit catches the wrap past 2**PW; that carry is the strobe.
  assign w_sum = {1'b0, r_acc} + {1'b0, inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_stb <= 1'b0;
    end else if (run) begin
      r_acc <= w_sum[PW-1:0];
      r_stb <= w_sum[PW];
    end else begin
      r_stb <= 1'b0;
    end
  end

  assign stb = r_stb;

endmodule

// File: rtl/intp_deci_sched.sv
// intp_deci_sched: strobe scheduler for the interpolation/decimation hold
// stage. Two phase accumulators generate the eni/eno enables; the block also
// holds the shadow rate configuration, tracks hold-register occupancy and
// counts dropped/zero-filled samples.
//   clk  clock
//   rst  synchronous active-high reset
//   bus  intp_deci_sched_if slave: run, cfg_*, cnt_clr in; strobes/status out
module intp_deci_sched
  import intp_deci_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int CW = CW_DEF
) (
  input logic                clk,
  input logic                rst,
  intp_deci_sched_if.slave   bus
);

  // Same layout as rate_cfg_t, sized to this instance's accumulator width.
  typedef struct packed {
    logic [PW-1:0] inc_i;
    logic [PW-1:0] inc_o;
  } cfg_w_t;

  cfg_w_t        r_act;
  cfg_w_t        r_shadow;
  logic          r_pend;
  logic          r_full;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] r_fill;
  logic          w_eni;
  logic          w_eno;
  logic          w_apply;
  logic          w_drop_ev;
  logic          w_fill_ev;

  phase_acc_strobe #(.PW(PW)) u_acc_i (
    .clk (clk),
    .rst (rst),
    .run (bus.run),
    .inc (r_act.inc_i),
    .stb (w_eni)
  );

  phase_acc_strobe #(.PW(PW)) u_acc_o (
    .clk (clk),
    .rst (rst),
    .run (bus.run),
    .inc (r_act.inc_o),
    .stb (w_eno)
  );

  // New rates land on an output strobe so the output phase stays continuous.
  // With inc_o=0 no eno ever comes, so a pending config is taken at once.
  assign w_apply   = r_pend & (w_eno | (r_act.inc_o == '0));

  // eni and eno together on a full register: old sample leaves, new enters.
  assign w_drop_ev = w_eni & r_full & ~w_eno;
  assign w_fill_ev = w_eno & ~r_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_act    <= '0;
      r_shadow <= '0;
      r_pend   <= 1'b0;
      r_full   <= 1'b0;
      r_drop   <= '0;
      r_fill   <= '0;
    end else begin
      if (w_apply) begin
        r_act <= r_shadow;
      end

      // A write in the apply cycle refills the shadow and keeps it pending.
      if (bus.cfg_wr) begin
        r_shadow <= '{inc_i: bus.cfg_inc_i, inc_o: bus.cfg_inc_o};
        r_pend   <= 1'b1;
      end else if (w_apply) begin
        r_pend <= 1'b0;
      end

      if (w_eni) begin
        r_full <= 1'b1;
      end else if (w_eno) begin
        r_full <= 1'b0;
      end

      if (bus.cnt_clr) begin
        r_drop <= '0;
        r_fill <= '0;
      end else begin
        if (w_drop_ev && (r_drop != '1)) begin
          r_drop <= r_drop + 1'b1;
        end
        if (w_fill_ev && (r_fill != '1)) begin
          r_fill <= r_fill + 1'b1;
        end
      end
    end
  end

  assign bus.eni      = w_eni;
  assign bus.eno      = w_eno;
  assign bus.full     = r_full;
  assign bus.cfg_pend = r_pend;
  assign bus.drop_cnt = r_drop;
  assign bus.fill_cnt = r_fill;

endmodule

// File: tb/tb_intp_deci_sched.sv
// tb_intp_deci_sched: self-checking bench for intp_deci_sched at PW=8, CW=4.
// A table of hand-derived vectors covers reset and 2:1 decimation, directed
// sequences cover interpolation, run gating, reconfiguration, saturation and
// reset mid-run, and a random phase is checked every cycle against a
// behavioural model of the rate/occupancy rules.
module tb_intp_deci_sched;
  import intp_deci_pkg::*;

  localparam int PW  = 8;
  localparam int CW  = 4;
  localparam int MOD = 1 << PW;
  localparam int SAT = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  intp_deci_sched_if #(.PW(PW), .CW(CW)) bus ();

  intp_deci_sched #(.PW(PW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  int m_acc_i, m_acc_o, m_inc_i, m_inc_o, m_sh_i, m_sh_o, m_drop, m_fill;
  bit m_pend, m_eni, m_eno, m_full;

  task automatic model_reset();
    m_acc_i = 0; m_acc_o = 0; m_inc_i = 0; m_inc_o = 0;
    m_sh_i = 0; m_sh_o = 0; m_drop = 0; m_fill = 0;
    m_pend = 0; m_eni = 0; m_eno = 0; m_full = 0;
  endtask

  // One clock of the scheduler rules, using the inputs present at the edge.
  task automatic model_step();
    bit n_eni, n_eno, apply;
    if (rst) begin
      model_reset();
      return;
    end
    apply = m_pend && (m_eno || m_inc_o == 0);
    n_eni = 0;
    n_eno = 0;
    if (bus.run) begin
      n_eni   = (m_acc_i + m_inc_i) >= MOD;
      n_eno   = (m_acc_o + m_inc_o) >= MOD;
      m_acc_i = (m_acc_i + m_inc_i) % MOD;
      m_acc_o = (m_acc_o + m_inc_o) % MOD;
    end
    if (bus.cnt_clr) begin
      m_drop = 0;
      m_fill = 0;
    end else begin
      if (m_eni && m_full && !m_eno && m_drop < SAT) m_drop++;
      if (m_eno && !m_full && m_fill < SAT) m_fill++;
    end
    if (m_eni)      m_full = 1;
    else if (m_eno) m_full = 0;
    if (apply) begin
      m_inc_i = m_sh_i;
      m_inc_o = m_sh_o;
    end
    if (bus.cfg_wr) begin
      m_sh_i = int'(bus.cfg_inc_i);
      m_sh_o = int'(bus.cfg_inc_o);
      m_pend = 1;
    end else if (apply) begin
      m_pend = 0;
    end
    m_eni = n_eni;
    m_eno = n_eno;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    chk("eni",      int'(bus.eni),      int'(m_eni));
    chk("eno",      int'(bus.eno),      int'(m_eno));
    chk("full",     int'(bus.full),     int'(m_full));
    chk("cfg_pend", int'(bus.cfg_pend), int'(m_pend));
    chk("drop_cnt", int'(bus.drop_cnt), m_drop);
    chk("fill_cnt", int'(bus.fill_cnt), m_fill);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic drive(input bit r, input bit run, input bit wr, input int ii,
                       input int io, input bit clr);
    rst           = r;
    bus.run       = run;
    bus.cfg_wr    = wr;
    bus.cfg_inc_i = PW'(ii);
    bus.cfg_inc_o = PW'(io);
    bus.cnt_clr   = clr;
  endtask

  // Ticks until eno is seen (bounded); n returns the number of ticks taken.
  task automatic tick_until_eno(input int lim, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.eno && n < lim);
    chk("eno_seen", int'(bus.eno), 1);
  endtask

  task automatic load_cfg(input int ii, input int io);
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 1, ii, io, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  typedef struct {
    bit rst, run, wr;
    int inc_i, inc_o;
    bit clr;
    int eni, eno, full, pend, drop, fill;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(bit r, bit run, bit wr, int ii, int io, bit clr,
                              int eni, int eno, int full, int pend, int drop, int fill);
    vec_t v;
    v.rst = r; v.run = run; v.wr = wr; v.inc_i = ii; v.inc_o = io; v.clr = clr;
    v.eni = eni; v.eno = eno; v.full = full; v.pend = pend; v.drop = drop; v.fill = fill;
    return v;
  endfunction

  initial begin
    int n;
    model_reset();
    drive(1, 0, 0, 0, 0, 0);

    // Reset, config load (applied at once since inc_o=0), then 2:1 decimation.
    tbl[0]  = mk(1, 0, 0,   0,  0, 0,  0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 128, 64, 0,  0, 0, 0, 1, 0, 0);
    tbl[2]  = mk(0, 0, 0,   0,  0, 0,  0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0,   0,  0, 0,  0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 0,   0,  0, 0,  1, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 1, 0,   0,  0, 0,  0, 0, 1, 0, 0, 0);
    tbl[6]  = mk(0, 1, 0,   0,  0, 0,  1, 1, 1, 0, 0, 0);
    tbl[7]  = mk(0, 1, 0,   0,  0, 0,  0, 0, 1, 0, 0, 0);
    tbl[8]  = mk(0, 1, 0,   0,  0, 0,  1, 0, 1, 0, 0, 0);
    tbl[9]  = mk(0, 1, 0,   0,  0, 0,  0, 0, 1, 0, 1, 0);
    tbl[10] = mk(0, 1, 0,   0,  0, 0,  1, 1, 1, 0, 1, 0);
    tbl[11] = mk(0, 1, 0,   0,  0, 0,  0, 0, 1, 0, 1, 0);
    tbl[12] = mk(0, 1, 0,   0,  0, 0,  1, 0, 1, 0, 1, 0);
    tbl[13] = mk(0, 1, 0,   0,  0, 0,  0, 0, 1, 0, 2, 0);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, tbl[i].run, tbl[i].wr, tbl[i].inc_i, tbl[i].inc_o, tbl[i].clr);
      tick();
      chk($sformatf("tbl%0d_eni", i),  int'(bus.eni),      tbl[i].eni);
      chk($sformatf("tbl%0d_eno", i),  int'(bus.eno),      tbl[i].eno);
      chk($sformatf("tbl%0d_full", i), int'(bus.full),     tbl[i].full);
      chk($sformatf("tbl%0d_pend", i), int'(bus.cfg_pend), tbl[i].pend);
      chk($sformatf("tbl%0d_drop", i), int'(bus.drop_cnt), tbl[i].drop);
      chk($sformatf("tbl%0d_fill", i), int'(bus.fill_cnt), tbl[i].fill);
    end

    // Interpolation 1:2: one zero-fill per 4 clk, no drops.
    load_cfg(64, 128);
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) tick();
    chk("interp_fill", int'(bus.fill_cnt), 4);
    chk("interp_drop", int'(bus.drop_cnt), 0);

    // Run gating: 5 idle clocks stretch the eno interval from 4 to 9.
    load_cfg(128, 64);
    drive(0, 1, 0, 0, 0, 0);
    tick_until_eno(20, n);
    tick_until_eno(20, n);
    chk("eno_period64", n, 4);
    bus.run = 0;
    for (int i = 0; i < 5; i++) tick();
    bus.run = 1;
    tick_until_eno(20, n);
    chk("run_gap", n + 5, 9);

    // Reconfig right after an eno: two writes, the last one (32) must win.
    drive(0, 1, 1, 128, 16, 0);
    tick();
    drive(0, 1, 1, 128, 32, 0);
    tick();
    chk("pend_after_wr", int'(bus.cfg_pend), 1);
    drive(0, 1, 0, 0, 0, 0);
    tick_until_eno(20, n);
    tick();
    chk("pend_applied", int'(bus.cfg_pend), 0);
    tick_until_eno(20, n);
    tick_until_eno(20, n);
    chk("eno_period32", n, 8);

    // Saturation: no output strobe, eni every 2 clk, drops pile up past 15.
    drive(0, 1, 1, 128, 0, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0);
    n = 0;
    while (bus.cfg_pend && n < 20) begin
      tick();
      n++;
    end
    chk("sat_cfg_landed", int'(bus.cfg_pend), 0);
    for (int i = 0; i < 40; i++) tick();
    chk("drop_sat", int'(bus.drop_cnt), SAT);
    n = 0;
    while (!bus.eni && n < 4) begin
      tick();
      n++;
    end
    bus.cnt_clr = 1;
    tick();
    bus.cnt_clr = 0;
    chk("clr_wins", int'(bus.drop_cnt), 0);

    // Reset mid-run: everything clears at the first edge, no strobes.
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_eni",  int'(bus.eni),      0);
      chk("rst_eno",  int'(bus.eno),      0);
      chk("rst_full", int'(bus.full),     0);
      chk("rst_drop", int'(bus.drop_cnt), 0);
    end
    rst = 0;

    // Random stimulus against the model.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 149) == 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 14) == 0, $urandom_range(0, 255),
            $urandom_range(0, 255), $urandom_range(0, 59) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
